dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU load/store path (loadi/mov/ALU datapath extended with lwd/swd/lwi/swi) and the data memory.
- Holds tag/valid/dirty state and block storage.
- Stalls the CPU via BUSYWAIT while a miss is serviced.
- Sequences data-memory block write-back and fetch through a 4-state FSM.

Parameters:
INDEX_BITS, 3, log2 of block count (8 blocks); tag width = 6 - INDEX_BITS; block = 4 bytes, offset = ADDRESS[1:0]

Ports:
CLK  input  1  processor clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
READ  input  1  CPU load request, held until BUSYWAIT low at an edge
WRITE  input  1  CPU store request, held until BUSYWAIT low at an edge
ADDRESS  input  8  CPU byte address {tag, index, offset}
WRITEDATA  input  8  CPU store byte
READDATA  output  8  load byte, combinational from the cache array
BUSYWAIT  output  1  CPU stall; PC and register writes freeze while high
MEM_READ  output  1  block read request to data memory
MEM_WRITE  output  1  block write request to data memory
MEM_ADDRESS  output  6  block address {tag, index}
MEM_WRITEDATA  output  32  victim block; byte 0 in [7:0]
MEM_READDATA  input  32  fetched block; byte 0 in [7:0]
MEM_BUSYWAIT  input  1  high while memory is busy

Behaviour:
- Decode: offset = ADDRESS[1:0], index = ADDRESS[2+:INDEX_BITS], tag = ADDRESS[7:2+INDEX_BITS]. hit = valid[index] & (tag_array[index] == tag).
- Memory contract: MEM_BUSYWAIT rises combinationally in the same cycle as MEM_READ or MEM_WRITE. A transfer completes at the first rising edge with MEM_BUSYWAIT = 0 while the request is held.
- States: IDLE, WRITEBACK, ALLOCATE, UPDATE.
- BUSYWAIT = (READ | WRITE) & ~(state == IDLE & hit). It is combinational, so a hit costs zero stall cycles.
- READDATA = byte[offset] of block[index] whenever READ is high. When READ is low, READDATA holds 8'h00.
- IDLE:
  - Write hit: at the edge, store WRITEDATA into byte[offset] and set dirty[index] = 1.
  - Read hit: no state change.
  - Miss with dirty[index] = 1: go to WRITEBACK.
  - Miss with dirty[index] = 0: go to ALLOCATE.
- WRITEBACK:
  - Outputs: MEM_WRITE = 1, MEM_ADDRESS = {tag_array[index], index}, MEM_WRITEDATA = block[index].
  - On completion, go to ALLOCATE.
- ALLOCATE:
  - Outputs: MEM_READ = 1, MEM_ADDRESS = {tag, index}.
  - On completion, write block[index] = MEM_READDATA, tag_array[index] = tag, valid = 1, dirty = 0, then go to UPDATE.
- UPDATE: 1 cycle with no memory request, then go to IDLE. The held request then hits; a store completes there and sets dirty.
- MEM_READ/MEM_WRITE are never high together. Both are 0 in IDLE and UPDATE.
- MEM_ADDRESS and MEM_WRITEDATA are 0 when no request is active.
- Miss latency:
  - Clean miss: memory read cycles + 2 stall cycles.
  - Dirty miss: additionally adds the memory write cycles.
- READ and WRITE both high is illegal. The controller treats it as a write, and READDATA is don't-care.
- Request dropped mid-miss (READ/WRITE low in WRITEBACK/ALLOCATE): the FSM completes the current transfer sequence and returns to IDLE. The fetched block is still installed.
- Reset:
  - At the edge: state = IDLE; all valid and dirty bits cleared; block and tag contents unspecified.
  - Outputs after reset: BUSYWAIT = READ|WRITE (everything misses); MEM_READ = MEM_WRITE = 0; MEM_ADDRESS = 0; MEM_WRITEDATA = 0.
  - Reset mid-miss abandons the transfer; dirty data is lost by design.
- ADDRESS and WRITEDATA must be stable while BUSYWAIT is high. The controller does not latch them.

Test Plan:
- Reset, then READ ADDRESS=8'h05 (memory block 1 = 32'hDDCCBBAA) -> BUSYWAIT high; MEM_READ with MEM_ADDRESS=6'h01, no MEM_WRITE; after UPDATE, READDATA=8'hBB and BUSYWAIT low; repeat read -> zero stall.
- WRITE 8'h5A to 8'h06 after that fill -> no stall; dirty set; READ 8'h06 -> 8'h5A with no memory access.
- READ 8'h25 (same index 1, tag 1) while dirty -> MEM_WRITE, MEM_ADDRESS=6'h01, MEM_WRITEDATA=32'hDD5ABBAA, then MEM_READ, MEM_ADDRESS=6'h09; final READDATA = byte 1 of memory block 9.
- Write miss to clean index, 8'h10 <- 8'h77 -> ALLOCATE only (no MEM_WRITE); READ 8'h10 afterwards returns 8'h77 and line is dirty.
- Memory busywait held for 5 cycles on a clean miss -> CPU BUSYWAIT high exactly 5+2 cycles; MEM_READ stable throughout.
- Assert RESET during ALLOCATE -> next cycle MEM_READ=0, state IDLE; prior hit address now misses.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU load/store
// path and a block-wide data memory; stalls the CPU while a miss is serviced.
module dcache_controller #(
  parameter int INDEX_BITS = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  localparam int TAG_BITS   = 6 - INDEX_BITS;
  localparam int NUM_BLOCKS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE,
    S_UPDATE
  } state_t;

  state_t                r_state;
  logic [NUM_BLOCKS-1:0] r_valid;
  logic [NUM_BLOCKS-1:0] r_dirty;
  logic [TAG_BITS-1:0]   r_tags   [NUM_BLOCKS];
  logic [31:0]           r_blocks [NUM_BLOCKS];
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [5:0]            r_mem_address;
  logic [31:0]           r_mem_writedata;

  logic [1:0]            w_offset;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_req;
  logic                  w_hit;
  logic [31:0]           w_block;
  logic [4:0]            w_byte_lsb;
  logic [INDEX_BITS-1:0] w_fill_index;
  logic [TAG_BITS-1:0]   w_fill_tag;

  assign w_offset   = ADDRESS[1:0];
  assign w_index    = ADDRESS[2 +: INDEX_BITS];
  assign w_tag      = ADDRESS[7:2+INDEX_BITS];
  assign w_req      = READ | WRITE;
  assign w_hit      = r_valid[w_index] & (r_tags[w_index] == w_tag);
  assign w_block    = r_blocks[w_index];
  assign w_byte_lsb = {w_offset, 3'b000};

  // The fill lands where the outstanding read was aimed, not wherever ADDRESS
  // points now, so a request dropped mid-miss still installs a coherent line.
  assign w_fill_index = r_mem_address[INDEX_BITS-1:0];
  assign w_fill_tag   = r_mem_address[5:INDEX_BITS];

  // A hit in IDLE releases the CPU in the same cycle; every other case stalls.
  assign BUSYWAIT = w_req & ~((r_state == S_IDLE) & w_hit);
  assign READDATA = READ ? w_block[w_byte_lsb +: 8] : 8'h00;

  assign MEM_READ      = r_mem_read;
  assign MEM_WRITE     = r_mem_write;
  assign MEM_ADDRESS   = r_mem_address;
  assign MEM_WRITEDATA = r_mem_writedata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: tag and block arrays are deliberately left out of reset; the
      // cleared valid bits already make their contents unobservable.
      r_state         <= S_IDLE;
      r_valid         <= '0;
      r_dirty         <= '0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && w_hit) begin
            if (WRITE) begin
              r_blocks[w_index][w_byte_lsb +: 8] <= WRITEDATA;
              r_dirty[w_index]                   <= 1'b1;
            end
          end else if (w_req) begin
            if (r_dirty[w_index]) begin
              r_state         <= S_WRITEBACK;
              r_mem_write     <= 1'b1;
              r_mem_address   <= {r_tags[w_index], w_index};
              r_mem_writedata <= w_block;
            end else begin
              r_state       <= S_ALLOCATE;
              r_mem_read    <= 1'b1;
              r_mem_address <= {w_tag, w_index};
            end
          end
        end

        S_WRITEBACK: begin
          if (!MEM_BUSYWAIT) begin
            r_state         <= S_ALLOCATE;
            r_mem_write     <= 1'b0;
            r_mem_read      <= 1'b1;
            r_mem_address   <= {w_tag, r_mem_address[INDEX_BITS-1:0]};
            r_mem_writedata <= '0;
          end
        end

        S_ALLOCATE: begin
          if (!MEM_BUSYWAIT) begin
            r_blocks[w_fill_index] <= MEM_READDATA;
            r_tags[w_fill_index]   <= w_fill_tag;
            r_valid[w_fill_index]  <= 1'b1;
            r_dirty[w_fill_index]  <= 1'b0;
            r_mem_read             <= 1'b0;
            r_mem_address          <= '0;
            r_state                <= S_UPDATE;
          end
        end

        S_UPDATE: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: behavioural block memory with settable
// latency, a bus monitor, and hand-computed expectations for each access.
module tb_dcache_controller;

  logic        CLK;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  dcache_controller #(.INDEX_BITS(3)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .READ         (READ),
    .WRITE        (WRITE),
    .ADDRESS      (ADDRESS),
    .WRITEDATA    (WRITEDATA),
    .READDATA     (READDATA),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_WRITE    (MEM_WRITE),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: a request lasts mem_lat cycles, busy rises with the request.
  int          mem_lat = 2;
  int          mem_cnt = 0;
  bit          mem_ready;
  logic [31:0] mem_model [64];

  function automatic logic [31:0] init_word(input logic [5:0] a);
    case (a)
      6'd1:    return 32'hDDCCBBAA;
      6'd9:    return 32'h44332211;
      default: return {4{2'b10, a}};
    endcase
  endfunction

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt < mem_lat - 1);
  assign MEM_READDATA = MEM_READ ? mem_model[MEM_ADDRESS] : 32'h0;

  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem_model[i] <= init_word(6'(i));
      mem_ready <= 1'b1;
    end else if (MEM_READ | MEM_WRITE) begin
      if (!MEM_BUSYWAIT) begin
        mem_cnt <= 0;
        if (MEM_WRITE) mem_model[MEM_ADDRESS] <= MEM_WRITEDATA;
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  // Bus monitor, sampled on the falling edge.
  int          mon_rd = 0, mon_wr = 0, mon_both = 0, mon_rd_starts = 0;
  logic [5:0]  mon_rd_addr = '0, mon_wr_addr = '0;
  logic [31:0] mon_wr_data = '0;
  logic        mon_prev_rd = 1'b0;

  always @(negedge CLK) begin
    if (MEM_READ) begin
      mon_rd++;
      mon_rd_addr = MEM_ADDRESS;
      if (!mon_prev_rd) mon_rd_starts++;
    end
    if (MEM_WRITE) begin
      mon_wr++;
      mon_wr_addr = MEM_ADDRESS;
      mon_wr_data = MEM_WRITEDATA;
    end
    if (MEM_READ && MEM_WRITE) mon_both++;
    mon_prev_rd = MEM_READ;
  end

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  // Per-access results, written only by the main process.
  int          acc_stall;
  int          acc_rd, acc_wr, acc_starts;
  logic [7:0]  acc_rdata;

  task automatic do_access(input logic rd, input logic wr,
                           input logic [7:0] addr, input logic [7:0] wd);
    int rd0, wr0, st0;
    rd0 = mon_rd; wr0 = mon_wr; st0 = mon_rd_starts;
    @(negedge CLK);
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
    #1;
    acc_stall = 0;
    while (BUSYWAIT && acc_stall < 200) begin
      acc_stall++;
      @(negedge CLK);
      #1;
    end
    if (BUSYWAIT) check("busywait_timeout", 32'(BUSYWAIT), 32'h0);
    acc_rdata = READDATA;
    @(posedge CLK);
    #1;
    READ = 1'b0; WRITE = 1'b0;
    acc_rd     = mon_rd - rd0;
    acc_wr     = mon_wr - wr0;
    acc_starts = mon_rd_starts - st0;
  endtask

  initial begin
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("rst_mem_read",  32'(MEM_READ), 32'h0);
    check("rst_mem_write", 32'(MEM_WRITE), 32'h0);
    check("rst_mem_addr",  32'(MEM_ADDRESS), 32'h0);
    check("rst_mem_wdata", MEM_WRITEDATA, 32'h0);
    check("rst_busywait",  32'(BUSYWAIT), 32'h0);
    check("rst_readdata",  32'(READDATA), 32'h0);

    // Clean read miss on block 1.
    do_access(1'b1, 1'b0, 8'h05, 8'h00);
    check("miss05_stall", 32'(acc_stall), 32'd4);
    check("miss05_data",  32'(acc_rdata), 32'hBB);
    check("miss05_rd",    32'(acc_rd), 32'd2);
    check("miss05_wr",    32'(acc_wr), 32'd0);
    check("miss05_addr",  32'(mon_rd_addr), 32'h01);
    check("idle_mem_addr", 32'(MEM_ADDRESS), 32'h0);

    do_access(1'b1, 1'b0, 8'h05, 8'h00);
    check("hit05_stall", 32'(acc_stall), 32'd0);
    check("hit05_data",  32'(acc_rdata), 32'hBB);
    check("hit05_rd",    32'(acc_rd), 32'd0);

    // Write hit, then read back without memory traffic.
    do_access(1'b0, 1'b1, 8'h06, 8'h5A);
    check("wrhit06_stall", 32'(acc_stall), 32'd0);
    do_access(1'b1, 1'b0, 8'h06, 8'h00);
    check("rd06_stall", 32'(acc_stall), 32'd0);
    check("rd06_data",  32'(acc_rdata), 32'h5A);
    check("rd06_mem",   32'(acc_rd + acc_wr), 32'd0);

    // Conflict miss on the dirty line: write-back then fetch of block 9.
    do_access(1'b1, 1'b0, 8'h25, 8'h00);
    check("miss25_stall",   32'(acc_stall), 32'd6);
    check("miss25_wr",      32'(acc_wr), 32'd2);
    check("miss25_wb_addr", 32'(mon_wr_addr), 32'h01);
    check("miss25_wb_data", mon_wr_data, 32'hDD5ABBAA);
    check("miss25_rd_addr", 32'(mon_rd_addr), 32'h09);
    check("miss25_data",    32'(acc_rdata), 32'h22);
    check("miss25_idle_wd", MEM_WRITEDATA, 32'h0);

    // Write miss to a clean index: allocate only, then the store lands.
    do_access(1'b0, 1'b1, 8'h10, 8'h77);
    check("wmiss10_stall", 32'(acc_stall), 32'd4);
    check("wmiss10_wr",    32'(acc_wr), 32'd0);
    check("wmiss10_addr",  32'(mon_rd_addr), 32'h04);
    do_access(1'b1, 1'b0, 8'h10, 8'h00);
    check("rd10_data",  32'(acc_rdata), 32'h77);
    check("rd10_stall", 32'(acc_stall), 32'd0);
    // Evicting index 4 proves the line was marked dirty.
    do_access(1'b1, 1'b0, 8'h30, 8'h00);
    check("ev30_wb_addr", 32'(mon_wr_addr), 32'h04);
    check("ev30_wb_data", mon_wr_data, 32'h84848477);
    check("ev30_data",    32'(acc_rdata), 32'h8C);
    check("ev30_stall",   32'(acc_stall), 32'd6);

    // Slow memory: five-cycle read.
    mem_lat = 5;
    do_access(1'b1, 1'b0, 8'h08, 8'h00);
    check("slow08_stall",  32'(acc_stall), 32'd7);
    check("slow08_rd",     32'(acc_rd), 32'd5);
    check("slow08_starts", 32'(acc_starts), 32'd1);
    check("slow08_data",   32'(acc_rdata), 32'h82);

    do_access(1'b1, 1'b0, 8'h25, 8'h00);
    check("hit25_stall", 32'(acc_stall), 32'd0);

    // Reset while a fill is in flight.
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 8'h0C;
    @(negedge CLK);
    #1;
    check("alloc0c_rd",   32'(MEM_READ), 32'h1);
    check("alloc0c_addr", 32'(MEM_ADDRESS), 32'h03);
    RESET = 1'b1;
    @(negedge CLK);
    #1;
    check("rstmid_rd",   32'(MEM_READ), 32'h0);
    check("rstmid_addr", 32'(MEM_ADDRESS), 32'h0);
    check("rstmid_busy", 32'(BUSYWAIT), 32'h1);
    RESET = 1'b0; READ = 1'b0;
    mem_lat = 2;

    do_access(1'b1, 1'b0, 8'h25, 8'h00);
    check("post_rst25_stall", 32'(acc_stall), 32'd4);
    check("post_rst25_wr",    32'(acc_wr), 32'd0);
    check("post_rst25_data",  32'(acc_rdata), 32'h22);

    check("rd_wr_overlap", 32'(mon_both), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
